// File: rtl/matrix_entry_loader.sv
`timescale 1ns/1ps
// Operand entry front-end: debounces key1, stages N*N elements of A then B from
// the switches, and publishes both matrices atomically when the last B element lands.
module matrix_entry_loader #(
  parameter int WIDTH           = 8,
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key1,
  input  logic [9:0]             SW,
  output logic [N*N*WIDTH-1:0]   mat_a,
  output logic [N*N*WIDTH-1:0]   mat_b,
  output logic                   mat_valid,
  output logic [9:0]             LED
);

  localparam int NE    = N * N;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef logic [NE-1:0][WIDTH-1:0] mat_t;

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  logic             press;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  mat_t             stage_a_q, stage_a_d;
  mat_t             stage_b_q, stage_b_d;
  mat_t             mat_a_q, mat_a_d;
  mat_t             mat_b_q, mat_b_d;
  logic             valid_q, valid_d;
  logic             unused_sw;

  assign unused_sw = ^SW;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q + CNT_W'(1);
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end
  end

  // A key held low across reset must be seen released before it can press:
  // arm only once the synchronizer holds real samples showing a stable high.
  assign armed_d = armed_q | (fill_q[1] & s2_q & db_q);
  assign press   = armed_q & db_q & ~db_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= key1;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_a_d = stage_a_q;
    stage_b_d = stage_b_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    valid_d   = valid_q;
    if (press) begin
      if (SW[9]) begin
        state_d = LOAD_A;
        idx_d   = '0;
      end else begin
        case (state_q)
          LOAD_A: begin
            stage_a_d[idx_q] = SW[WIDTH-1:0];
            if (idx_q == IDX_LAST) begin
              state_d = LOAD_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          LOAD_B: begin
            stage_b_d[idx_q] = SW[WIDTH-1:0];
            if (idx_q == IDX_LAST) begin
              // commit takes the B element written on this very edge
              mat_a_d = stage_a_q;
              mat_b_d = stage_b_d;
              valid_d = 1'b1;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          DONE: begin
            valid_d = 1'b0;
            state_d = LOAD_A;
            idx_d   = '0;
          end
          default: begin
            state_d = LOAD_A;
            idx_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      stage_a_q <= '0;
      stage_b_q <= '0;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      mat_a_q   <= mat_a_d;
      mat_b_q   <= mat_b_d;
      valid_q   <= valid_d;
    end
  end

  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign mat_valid = valid_q;
  assign LED       = {valid_q, state_q == LOAD_B, 8'(idx_q)};

endmodule

// File: tb/tb_matrix_entry_loader.sv
`timescale 1ns/1ps
// Bench for matrix_entry_loader: directed and random presses against an
// entry-count model of the A/B staging and commit behaviour.
module tb_matrix_entry_loader;
  localparam int WIDTH = 8;
  localparam int N     = 2;
  localparam int DC    = 4;
  localparam int NE    = N * N;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        key1 = 1'b1;
  logic [9:0]  SW   = '0;
  logic [31:0] mat_a, mat_b;
  logic        mat_valid;
  logic [9:0]  LED;

  int checks = 0;
  int errors = 0;

  logic [7:0] sa[NE], sb[NE], ma[NE], mb[NE];
  bit         mvalid, mdone;
  int         mcnt;

  matrix_entry_loader #(.WIDTH(WIDTH), .N(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .key1(key1), .SW(SW),
    .mat_a(mat_a), .mat_b(mat_b), .mat_valid(mat_valid), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_a();
    logic [31:0] r;
    for (int k = 0; k < NE; k++) r[k*8 +: 8] = ma[k];
    return r;
  endfunction

  function automatic logic [31:0] exp_b();
    logic [31:0] r;
    for (int k = 0; k < NE; k++) r[k*8 +: 8] = mb[k];
    return r;
  endfunction

  function automatic logic [9:0] exp_led();
    logic [9:0] r;
    r[9]   = mvalid;
    r[8]   = !mdone && (mcnt >= NE);
    r[7:0] = 8'(mdone ? NE - 1 : mcnt % NE);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NE; k++) begin
      sa[k] = '0; sb[k] = '0; ma[k] = '0; mb[k] = '0;
    end
    mvalid = 0; mdone = 0; mcnt = 0;
  endtask

  // Entries counted 0..2*NE-1: first NE go to A, the rest to B.
  task automatic model_press(input logic [9:0] sw);
    if (sw[9]) begin
      mcnt = 0; mdone = 0;
    end else if (mdone) begin
      mdone = 0; mvalid = 0; mcnt = 0;
    end else begin
      if (mcnt < NE) sa[mcnt] = sw[7:0];
      else           sb[mcnt-NE] = sw[7:0];
      mcnt++;
      if (mcnt == 2*NE) begin
        ma = sa; mb = sb; mvalid = 1; mdone = 1; mcnt = 0;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".mat_a"}, 64'(mat_a), 64'(exp_a()));
    chk({tag, ".mat_b"}, 64'(mat_b), 64'(exp_b()));
    chk({tag, ".valid"}, 64'(mat_valid), 64'(mvalid));
    chk({tag, ".led"},   64'(LED), 64'(exp_led()));
  endtask

  // Called right after key1 has been driven low at a negedge and held there.
  task automatic finish_press(input logic [9:0] sw);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk); chk_all("pre_edge");
    @(negedge clk); model_press(sw); chk_all("write_edge");
    repeat (2) @(negedge clk);
    key1 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic press(input logic [9:0] sw);
    @(negedge clk);
    SW   = sw;
    key1 = 1'b0;
    finish_press(sw);
  endtask

  function automatic logic [9:0] rnd_val();
    return 10'($urandom_range(0, 511));
  endfunction

  initial begin
    int clean_v[8] = '{4, 5, 2, 6, 1, 3, 7, 2};
    int cexp[4]    = '{39, 22, 44, 18};
    int c;
    logic [9:0] sw;

    model_reset();
    repeat (3) @(negedge clk);
    chk_all("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("post_reset");

    // clean entry with the reference operands
    for (int i = 0; i < 8; i++) press(10'(clean_v[i]));
    chk("clean.mat_a_const", 64'(mat_a), 64'h06020504);
    chk("clean.mat_b_const", 64'(mat_b), 64'h02070301);
    chk("clean.valid_const", 64'(mat_valid), 64'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < N; k++)
          c += int'(mat_a[(i*N+k)*8 +: 8]) * int'(mat_b[(k*N+j)*8 +: 8]);
        chk("packing.product", 64'(c), 64'(cexp[i*N+j]));
      end

    // three-cycle low glitch must not register
    @(negedge clk);
    SW   = 10'h011;
    key1 = 1'b0;
    repeat (3) @(negedge clk);
    key1 = 1'b1;
    repeat (8) @(negedge clk);
    chk_all("glitch3");

    // bouncy press from DONE: restarts entry and drops mat_valid
    @(negedge clk);
    sw = 10'h0AB;
    SW = sw;
    for (int i = 0; i < 10; i++) begin
      key1 = i[0];
      repeat (2) @(negedge clk);
    end
    chk_all("bounce_quiet");
    key1 = 1'b0;
    finish_press(sw);

    // re-entry: committed outputs hold until the new commit
    for (int i = 0; i < 8; i++) press(rnd_val());

    // abort after five entries
    press(10'h000);
    for (int i = 0; i < 5; i++) press(rnd_val());
    press(10'h3FF);
    chk("abort.led_zero", 64'(LED), 64'd0);

    // mid-entry asynchronous reset with the key held low through release
    for (int i = 0; i < 8; i++) press(rnd_val());
    for (int i = 0; i < 3; i++) press(rnd_val());
    @(negedge clk);
    SW   = 10'h055;
    key1 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async.mat_a", 64'(mat_a), 64'd0);
    chk("rst_async.mat_b", 64'(mat_b), 64'd0);
    chk("rst_async.valid", 64'(mat_valid), 64'd0);
    chk("rst_async.led",   64'(LED), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_all("held_low");
    key1 = 1'b1;
    repeat (8) @(negedge clk);
    press(10'h055);
    chk("repress.led", 64'(LED), 64'd1);

    // random presses with occasional aborts
    for (int i = 0; i < 30; i++) begin
      sw = rnd_val();
      if ($urandom_range(0, 5) == 0) sw[9] = 1'b1;
      press(sw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
